// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared definitions for the bit-serial adder.
//   state_t        : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width in bits
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell -- combinational 1-bit full adder made of two half-adder stages
// and an OR that merges their carries.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic hs1, hc1, hc2;

   // first half adder: a + b
   assign hs1 = a ^ b;
   assign hc1 = a & b;
   // second half adder: partial sum + carry in
   assign s   = hs1 ^ ci;
   assign hc2 = hs1 & ci;
   assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller, one operand bit per cycle,
// LSB first. A result is ready WIDTH edges after the accepting edge.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin an addition (sampled only in IDLE)
//   a, b, cin   : operands and carry-in, captured on the accepting edge
//   busy        : high while not IDLE
//   done        : one-cycle pulse when sum/cout become valid
//   sum, cout   : result, held until the next accepted start
//   ovf         : signed overflow, present only when SERIAL_ADD_OVF_EN is defined
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co;

   fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_co;
               // result enters from the MSB side; after WIDTH shifts bit 0 sits at sum[0]
               sum   <= {fa_s, sum[WIDTH-1:1]};
               if (cnt == LAST) begin
                  cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                  // carry register here is the carry into the MSB
                  ovf   <= carry ^ fa_co;
`endif
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- self-checking bench for serial_add_ctrl (WIDTH=8):
// directed corner cases plus 1000 random operand triples against an
// arithmetic reference. Build with or without SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain integer addition, signed overflow from operand/result signs
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] r;
      r = ref_add(x, y, c);
      return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   task automatic chk_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] r;
      r = ref_add(x, y, c);
      chk({tag, "_sum"}, 64'(sum), 64'(r[W-1:0]));
      chk({tag, "_cout"}, 64'(cout), 64'(r[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(x, y, c)));
`endif
   endtask

   // Called at a negedge with the DUT idle. Runs one addition, checks latency,
   // result, single-cycle done and result hold afterwards.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input string tag, input bit full);
      int e;
      a = x; b = y; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (full) chk({tag, "_busy"}, 64'(busy), 64'd1);
      e = 0;
      while (!done && e < W + 4) begin
         @(negedge clk);
         e++;
      end
      chk({tag, "_lat"}, 64'(e), 64'(W));
      chk_result(tag, x, y, c);
      a = ~x; b = ~y;   // operands must not disturb the held result
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      if (full) begin
         chk({tag, "_idle"}, 64'(busy), 64'd0);
         @(negedge clk);
         chk_result({tag, "_hold"}, x, y, c);
      end
   endtask

   initial begin
      int e, g, ndone;
      logic [W-1:0] sum_at_done;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);

      // directed corner cases
      do_op(8'h3C, 8'h45, 1'b0, "d3c45", 1'b1);
      do_op(8'hFF, 8'h01, 1'b0, "dff01", 1'b1);
      do_op(8'hFF, 8'h00, 1'b1, "dff00c", 1'b1);
      do_op(8'hFF, 8'hFF, 1'b1, "dffffc", 1'b1);

      // start re-pulsed during RUN must be ignored
      a = 8'h3C; b = 8'h45; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; sum_at_done = '0;
      for (int i = 0; i < W + 6; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            sum_at_done = sum;
         end
      end
      chk("ign_ndone", 64'(ndone), 64'd1);
      chk("ign_sum", 64'(sum_at_done), 64'h81);

      // reset in the 4th RUN cycle aborts without a done pulse
      a = 8'h3C; b = 8'h45; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      ndone = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("abort_quiet", 64'(ndone), 64'd0);

      // start held: back-to-back results WIDTH+2 cycles apart
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      e = 0;
      while (!done && e < W + 4) begin
         @(negedge clk);
         e++;
      end
      chk("b2b_lat", 64'(e), 64'(W));
      chk_result("b2b_1", 8'h01, 8'h01, 1'b0);
      a = 8'h80; b = 8'h80;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!done && g < 3 * W);
      start = 1'b0;
      chk("b2b_gap", 64'(g), 64'(W + 2));
      chk_result("b2b_2", 8'h80, 8'h80, 1'b0);
      repeat (2) @(negedge clk);
      chk("b2b_idle", 64'(busy), 64'd0);

      // random operands with random idle gaps
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(ra, rb, rc, "rnd", 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
